scroll_msg_driver: RTL and testbench
====================================

SCROLL_MSG_DRIVER -- requirements
Module: scroll_msg_driver

Interface
REQ-001 Parameter DEPTH, default 16, message buffer capacity in codes (power of two, >= NDIG).
REQ-002 Parameter NDIG, default 4, number of multiplexed 7-segment digits.
REQ-003 Parameter REFRESH_DIV, default 50000, clk cycles per digit slot.
REQ-004 Parameter SCROLL_DIV, default 25000000, clk cycles per one-position scroll step.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 wr_valid  input  1  upstream presents wr_code.
REQ-008 wr_code  input  5  5-bit character code, the same encoding the 7-segment decoder consumes.
REQ-009 wr_last  input  1  qualifies wr_code as the final character of the message.
REQ-010 wr_ready  output  1  block accepts a code this cycle.
REQ-011 clear  input  1  synchronous discard of message, return to IDLE.
REQ-012 run  input  1  scroll enable; low freezes window position.
REQ-013 line  output  5  code for the currently selected digit; feeds the decoder's line input.
REQ-014 dig_en  output  NDIG  one-hot active-high digit select, aligned with line.
REQ-015 msg_len  output  $clog2(DEPTH)+1  committed message length, 0 when none.

Function
REQ-016 States: IDLE (no message), LOAD (partial message), SCROLL (committed message displayed).
REQ-017 Write handshake: code accepted on a cycle with wr_valid & wr_ready; stored at write pointer, pointer increments.
REQ-018 wr_ready = 1 in IDLE and LOAD, 0 in SCROLL.
REQ-019 IDLE -> LOAD on accepted write without wr_last; IDLE/LOAD -> SCROLL on accepted write with wr_last.
REQ-020 Accepted write at index DEPTH-1 is treated as last regardless of wr_last (buffer full -> SCROLL).
REQ-021 On entry to SCROLL: msg_len = codes stored, window start = 0, scroll counter = 0.
REQ-022 Displayed sequence is virtual ring of length L = msg_len + NDIG: positions 0..msg_len-1 = buffer, msg_len..L-1 = BLANK_CODE.
REQ-023 Digit k (k = 0 leftmost) shows ring[(start + k) mod L].
REQ-024 Scroll counter counts while run = 1 in SCROLL; at SCROLL_DIV-1 it wraps to 0 and start increments, wrapping L-1 -> 0.
REQ-025 run = 0 holds scroll counter and start; refresh continues.
REQ-026 Refresh counter runs in all states; at REFRESH_DIV-1 it wraps and digit index advances, NDIG-1 -> 0.
REQ-027 line and dig_en are registered, updated together one cycle after digit index/start change; never glitch between slots.
REQ-028 In IDLE and LOAD: line = BLANK_CODE, dig_en still cycles.
REQ-029 clear = 1 (any state): next cycle IDLE, write pointer 0, msg_len 0, start 0; clear wins over a same-cycle write (write dropped).
REQ-030 Arithmetic on start + k is done in width $clog2(DEPTH+NDIG)+1 with explicit modulo-L wrap; no truncation aliasing.

Reset
REQ-031 rst_n low asynchronously forces: IDLE, pointers/counters 0, msg_len 0, line = BLANK_CODE, dig_en = 0 for the first slot then one-hot from digit 0, wr_ready = 1.
REQ-032 Reset mid-LOAD or mid-SCROLL discards buffer contents logically (msg_len 0); buffer RAM itself need not be cleared.

Structure
REQ-033 Shared package holds BLANK_CODE (5'd31) and the state enum type.
REQ-034 One sub-module natural: digit_refresh_ctr (refresh counter + one-hot dig_en generation), reusable by other display blocks.

Verification
REQ-035 Reset, no writes, REFRESH_DIV=4, NDIG=4 -> line=31 every slot, dig_en 0001,0010,0100,1000 each 4 cycles, repeating.
REQ-036 Write codes 1,2,3 (last on 3), SCROLL_DIV=8 -> msg_len=3, digits show 1,2,3,31; after 8 run cycles 2,3,31,31; after 7 steps (L=7) back to 1,2,3,31.
REQ-037 Write 16 codes, wr_last never asserted -> SCROLL after 16th accept, wr_ready=0, msg_len=16.
REQ-038 run held low 100 cycles in SCROLL -> window unchanged, dig_en keeps cycling.
REQ-039 clear coincident with wr_valid&wr_last -> IDLE, msg_len=0, code not stored.
REQ-040 rst_n pulsed low mid-SCROLL, asynchronous to clk -> outputs to reset values immediately, IDLE after release.

Source files
------------

// File: rtl/scroll_msg_driver_pkg.sv
// scroll_msg_driver_pkg: blank character code and controller state type shared by the scroller
package scroll_msg_driver_pkg;
    localparam logic [4:0] BLANK_CODE = 5'd31;
    typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;
endpackage

// File: rtl/digit_refresh_ctr.sv
// digit_refresh_ctr: slot timer stepping a digit index and a registered one-hot digit enable
module digit_refresh_ctr #(
    parameter int NDIG = 4,
    parameter int REFRESH_DIV = 50000,
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [IW-1:0]   dig_idx,
    output logic [NDIG-1:0] dig_en
);
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    logic [CW-1:0] cnt;
    // dig_en lags dig_idx by one cycle so it lines up with the registered line code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dig_idx <= '0;
            dig_en  <= '0;
        end else begin
            dig_en <= NDIG'(1) << dig_idx;
            if (cnt == CW'(REFRESH_DIV - 1)) begin
                cnt     <= '0;
                dig_idx <= dig_idx == IW'(NDIG - 1) ? '0 : dig_idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/scroll_msg_driver.sv
// scroll_msg_driver: buffers a character message and scrolls it across multiplexed 7-segment digits
module scroll_msg_driver
    import scroll_msg_driver_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int NDIG = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int SCROLL_DIV = 25000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [4:0]               wr_code,
    input  logic                     wr_last,
    output logic                     wr_ready,
    input  logic                     clear,
    input  logic                     run,
    output logic [4:0]               line,
    output logic [NDIG-1:0]          dig_en,
    output logic [$clog2(DEPTH):0]   msg_len
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(DEPTH + NDIG) + 1;
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam int CW = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;

    state_t          state, nxt;
    logic [4:0]      mem [DEPTH];
    logic [LW-1:0]   wr_ptr;
    logic [CW-1:0]   scroll_cnt;
    logic [SW-1:0]   start, ring_len, pos_raw, pos;
    logic [IW-1:0]   dig_idx;
    logic            accept, is_last;
    logic [4:0]      line_d;

    digit_refresh_ctr #(.NDIG(NDIG), .REFRESH_DIV(REFRESH_DIV)) u_refresh (
        .clk(clk), .rst_n(rst_n), .dig_idx(dig_idx), .dig_en(dig_en)
    );

    assign wr_ready = state != SCROLL;
    assign accept   = wr_valid & wr_ready & ~clear;
    assign is_last  = wr_last | (wr_ptr == LW'(DEPTH - 1));

    // ring of msg_len buffer codes followed by NDIG blanks; one subtraction wraps since dig_idx < L
    assign ring_len = SW'(msg_len) + SW'(NDIG);
    assign pos_raw  = start + SW'(dig_idx);
    assign pos      = pos_raw >= ring_len ? pos_raw - ring_len : pos_raw;
    assign line_d   = state == SCROLL && pos < SW'(msg_len) ? mem[pos[AW-1:0]] : BLANK_CODE;

    always_comb begin
        nxt = state;
        if (clear) nxt = IDLE;
        else if (accept) nxt = is_last ? SCROLL : LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= wr_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            msg_len    <= '0;
            start      <= '0;
            scroll_cnt <= '0;
            line       <= BLANK_CODE;
        end else begin
            line <= line_d;
            if (clear) begin
                wr_ptr     <= '0;
                msg_len    <= '0;
                start      <= '0;
                scroll_cnt <= '0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (is_last) begin
                    msg_len    <= wr_ptr + 1'b1;
                    start      <= '0;
                    scroll_cnt <= '0;
                end
            end else if (state == SCROLL && run) begin
                if (scroll_cnt == CW'(SCROLL_DIV - 1)) begin
                    scroll_cnt <= '0;
                    start      <= start == ring_len - 1'b1 ? '0 : start + 1'b1;
                end else begin
                    scroll_cnt <= scroll_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_scroll_msg_driver.sv
// tb_scroll_msg_driver: directed table-driven checks of refresh, scrolling, clear and reset
module tb_scroll_msg_driver;
    logic       clk = 1'b0;
    logic       rst_n, wr_valid, wr_last, clear, run;
    logic [4:0] wr_code, line;
    logic       wr_ready;
    logic [3:0] dig_en;
    logic [4:0] msg_len;
    int         total = 0, passed = 0;

    scroll_msg_driver #(.DEPTH(16), .NDIG(4), .REFRESH_DIV(4), .SCROLL_DIV(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_code(wr_code), .wr_last(wr_last),
        .wr_ready(wr_ready), .clear(clear), .run(run), .line(line), .dig_en(dig_en), .msg_len(msg_len)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct { int cyc; logic [3:0] en; } idle_vec_t;
    typedef struct { int steps; logic [19:0] w; } scroll_vec_t;
    idle_vec_t   ivec[9];
    scroll_vec_t svec[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wr(input logic [4:0] c, input logic l);
        wr_valid = 1'b1;
        wr_code  = c;
        wr_last  = l;
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic step(input int n);
        run = 1'b1;
        repeat (8 * n) @(negedge clk);
        run = 1'b0;
    endtask

    // collects digit k's code by waiting for its enable; w holds digit 0 in the top bits
    task automatic read_window(output logic [19:0] w);
        w = '0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            int t = 0;
            while (dig_en !== (4'b1 << k) && t < 64) begin
                @(negedge clk);
                t++;
            end
            if (t >= 64) begin
                total++;
                $display("FAIL window_timeout: digit %0d dig_en=%b", k, dig_en);
            end
            w[19-5*k -: 5] = line;
        end
    endtask

    initial begin
        logic [19:0] w;
        logic [3:0]  seen;
        int          n;
        ivec = '{'{0, 4'b0000}, '{1, 4'b0001}, '{4, 4'b0001}, '{5, 4'b0010}, '{8, 4'b0010},
                 '{9, 4'b0100}, '{13, 4'b1000}, '{16, 4'b1000}, '{17, 4'b0001}};
        svec = '{'{0, {5'd1, 5'd2, 5'd3, 5'd31}},  '{1, {5'd2, 5'd3, 5'd31, 5'd31}},
                 '{1, {5'd3, 5'd31, 5'd31, 5'd31}}, '{1, {5'd31, 5'd31, 5'd31, 5'd31}},
                 '{1, {5'd31, 5'd31, 5'd31, 5'd1}}, '{1, {5'd31, 5'd31, 5'd1, 5'd2}},
                 '{1, {5'd31, 5'd1, 5'd2, 5'd3}},   '{1, {5'd1, 5'd2, 5'd3, 5'd31}}};
        rst_n = 1'b0; wr_valid = 1'b0; wr_code = '0; wr_last = 1'b0; clear = 1'b0; run = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_line", line, 5'd31);
        chk("rst_dig_en", dig_en, 4'b0000);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_msg_len", msg_len, 5'd0);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            while (n < ivec[i].cyc) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("idle_dig_en_c%0d", ivec[i].cyc), dig_en, ivec[i].en);
            chk($sformatf("idle_line_c%0d", ivec[i].cyc), line, 5'd31);
        end

        wr(5'd1, 1'b0);
        chk("load_wr_ready", wr_ready, 1'b1);
        chk("load_msg_len", msg_len, 5'd0);
        wr(5'd2, 1'b0);
        wr(5'd3, 1'b1);
        chk("scroll_wr_ready", wr_ready, 1'b0);
        chk("scroll_msg_len", msg_len, 5'd3);
        for (int i = 0; i < 8; i++) begin
            if (svec[i].steps > 0) step(svec[i].steps);
            read_window(w);
            chk($sformatf("window_step%0d", i), w, svec[i].w);
        end

        seen = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            seen |= dig_en;
        end
        chk("hold_dig_en_cycles", seen, 4'hF);
        read_window(w);
        chk("hold_window", w, {5'd1, 5'd2, 5'd3, 5'd31});

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_msg_len", msg_len, 5'd0);
        chk("clear_wr_ready", wr_ready, 1'b1);
        clear = 1'b1; wr_valid = 1'b1; wr_code = 5'd7; wr_last = 1'b1;
        @(negedge clk);
        clear = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
        chk("clear_wins_msg_len", msg_len, 5'd0);
        chk("clear_wins_wr_ready", wr_ready, 1'b1);
        wr(5'd9, 1'b1);
        chk("after_clear_msg_len", msg_len, 5'd1);
        read_window(w);
        chk("after_clear_window", w, {5'd9, 5'd31, 5'd31, 5'd31});

        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                chk("full_pre_wr_ready", wr_ready, 1'b1);
                chk("full_pre_msg_len", msg_len, 5'd0);
            end
            wr(5'(i), 1'b0);
        end
        chk("full_wr_ready", wr_ready, 1'b0);
        chk("full_msg_len", msg_len, 5'd16);
        read_window(w);
        chk("full_window0", w, {5'd0, 5'd1, 5'd2, 5'd3});
        step(13);
        read_window(w);
        chk("full_window13", w, {5'd13, 5'd14, 5'd15, 5'd31});
        step(5);
        read_window(w);
        chk("full_window18", w, {5'd31, 5'd31, 5'd0, 5'd1});

        run = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_line", line, 5'd31);
        chk("async_rst_dig_en", dig_en, 4'b0000);
        chk("async_rst_wr_ready", wr_ready, 1'b1);
        chk("async_rst_msg_len", msg_len, 5'd0);
        @(negedge clk);
        run = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_wr_ready", wr_ready, 1'b1);
        chk("post_rst_msg_len", msg_len, 5'd0);
        read_window(w);
        chk("post_rst_window", w, {5'd31, 5'd31, 5'd31, 5'd31});
        wr(5'd5, 1'b1);
        chk("post_rst_write_msg_len", msg_len, 5'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
